// File: rtl/sysarr_out_drain_buffer.sv
// Systolic array output drain: serial results -> N-lane rows -> DEPTH-row queue.
// Define SYSARR_OUTBUF_FLUSH_EN to add the partial-row flush port.
module sysarr_out_drain_buffer #(
  parameter int DW    = 16,
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       shift,
  input  logic [DW-1:0]              shift_value,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DW*N-1:0]            out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] row_count,
  output logic [$clog2(N)-1:0]       fill,
`ifdef SYSARR_OUTBUF_FLUSH_EN
  input  logic                       flush,
`endif
  output logic                       ovf
);

  localparam int FW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int RW = DW*N;

  logic [RW-1:0] asm;
  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;

  logic          full, last, accept;
  logic          push, pop;
  logic [RW-1:0] row_new, asm_s, push_data;
  logic [FW-1:0] fill_s;

  always_comb begin
    full     = (row_count == CW'(DEPTH));
    last     = (fill == FW'(N-1));
    in_ready = !last || !full;
    accept   = shift && in_ready;
    row_new  = {asm[DW*(N-1)-1:0], shift_value};
    asm_s    = accept ? row_new : asm;
    fill_s   = fill;
    if (accept) fill_s = last ? '0 : fill + FW'(1);
    push      = accept && last;
    push_data = row_new;
`ifdef SYSARR_OUTBUF_FLUSH_EN
    // elements sit in the low lanes; shift them up so e0 lands in lane N-1
    if (flush && fill_s != '0 && !full) begin
      push      = 1'b1;
      push_data = asm_s << (DW*(N-int'(fill_s)));
      fill_s    = '0;
    end
`endif
    out_valid = (row_count != '0);
    out_data  = out_valid ? mem[rd_ptr] : '0;
    pop       = out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      asm       <= '0;
      fill      <= '0;
      ovf       <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      row_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      asm  <= asm_s;
      fill <= fill_s;
      if (shift && !in_ready) ovf <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   row_count <= row_count + CW'(1);
        2'b01:   row_count <= row_count - CW'(1);
        default: row_count <= row_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sysarr_out_drain_buffer.sv
// Bench for sysarr_out_drain_buffer: directed scenarios plus random traffic
// checked against a queue-based row model.
module tb_sysarr_out_drain_buffer;

  localparam int DW = 16;
  localparam int N = 4;
  localparam int DEPTH = 2;

  logic        clk = 0;
  logic        nRST = 0;
  logic        shift = 0;
  logic [15:0] shift_value = 0;
  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic        out_ready = 0;
  logic [1:0]  row_count;
  logic [1:0]  fill;
  logic        ovf;
  logic        flush = 0;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] part[$];
  logic [63:0] q[$];
  logic        m_ovf;

  sysarr_out_drain_buffer #(.DW(DW), .N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .nRST(nRST), .shift(shift), .shift_value(shift_value),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .row_count(row_count), .fill(fill),
`ifdef SYSARR_OUTBUF_FLUSH_EN
    .flush(flush),
`endif
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] compose();
    logic [63:0] r = '0;
    foreach (part[i]) r |= 64'(part[i]) << (16*(N-1-i));
    return r;
  endfunction

  function automatic bit m_ir();
    return !(part.size() == N-1 && q.size() == DEPTH);
  endfunction

  function automatic logic [63:0] m_data();
    return (q.size() != 0) ? q[0] : 64'h0;
  endfunction

  // Drive one cycle from a negedge, update the model at the posedge,
  // return at the following negedge.
  task automatic step(input bit sh, input logic [15:0] v,
                      input bit ordy, input bit fl);
    bit ir, full, pop, push;
    logic [63:0] prow;
    shift = sh; shift_value = v; out_ready = ordy; flush = fl;
    ir = m_ir(); full = (q.size() == DEPTH);
    pop = (q.size() != 0) && ordy; push = 0; prow = '0;
    @(posedge clk);
    if (sh && !ir) m_ovf = 1;
    if (sh && ir) begin
      part.push_back(v);
      if (part.size() == N) begin
        prow = compose(); part.delete(); push = 1;
      end
    end
`ifdef SYSARR_OUTBUF_FLUSH_EN
    if (fl && !push && part.size() > 0 && !full) begin
      prow = compose(); part.delete(); push = 1;
    end
`endif
    if (pop) void'(q.pop_front());
    if (push) q.push_back(prow);
    @(negedge clk);
    shift = 0; out_ready = 0; flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRST = 0;
    part.delete(); q.delete(); m_ovf = 0;
    @(negedge clk);
    @(negedge clk);
    nRST = 1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 16'h0100 + 16'(i), 0, 0);
    #1 nRST = 0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_out ir=%b ov=%b od=%h exp 1 0 0", in_ready, out_valid, out_data);
    end
    vectors++;
    if (row_count !== 2'd0 || fill !== 2'd0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state rc=%0d fill=%0d ovf=%b exp 0 0 0", row_count, fill, ovf);
    end
    part.delete(); q.delete(); m_ovf = 0;
    @(negedge clk);
    nRST = 1;
    for (int i = 0; i < 4; i++) step(1, 16'h1111 * 16'(i+1), 0, 0);
    vectors++;
    if (out_data !== 64'h1111_2222_3333_4444) begin
      miscompares++;
      $display("FAIL reset_lane3 got %h exp %h", out_data, 64'h1111_2222_3333_4444);
    end
  endtask

  task automatic test_single_row();
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 16'(i), 0, 0);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 64'h0001_0002_0003_0004) begin
      miscompares++;
      $display("FAIL single_row ov=%b od=%h exp 1 %h", out_valid, out_data, 64'h0001_0002_0003_0004);
    end
    vectors++;
    if (row_count !== 2'd1 || fill !== 2'd0) begin
      miscompares++;
      $display("FAIL single_cnt rc=%0d fill=%0d exp 1 0", row_count, fill);
    end
  endtask

  task automatic test_backpressure();
    bit exp_ir;
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 16'h2000 + 16'(i), 0, 0);
    vectors++;
    if (row_count !== 2'd2 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_full rc=%0d ir=%b exp 2 1", row_count, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h3000 + 16'(i), 0, 0);
      exp_ir = (i < 2);
      vectors++;
      if (in_ready !== exp_ir) begin
        miscompares++;
        $display("FAIL bp_ready%0d got %b exp %b", i, in_ready, exp_ir);
      end
    end
    step(1, 16'hDEAD, 0, 0);
    vectors++;
    if (ovf !== 1'b1 || fill !== 2'd3 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drop ovf=%b fill=%0d ir=%b exp 1 3 0", ovf, fill, in_ready);
    end
    step(0, 0, 1, 0);
    vectors++;
    if (in_ready !== 1'b1 || row_count !== 2'd1) begin
      miscompares++;
      $display("FAIL bp_pop ir=%b rc=%0d exp 1 1", in_ready, row_count);
    end
    vectors++;
    if (out_data !== 64'h2004_2005_2006_2007) begin
      miscompares++;
      $display("FAIL bp_head got %h exp %h", out_data, 64'h2004_2005_2006_2007);
    end
    step(1, 16'h3003, 0, 0);
    vectors++;
    if (row_count !== 2'd2 || ovf !== m_ovf) begin
      miscompares++;
      $display("FAIL bp_refill rc=%0d ovf=%b exp 2 %b", row_count, ovf, m_ovf);
    end
    step(0, 0, 1, 0);
    vectors++;
    if (out_data !== 64'h3000_3001_3002_3003) begin
      miscompares++;
      $display("FAIL bp_drop_row got %h exp %h", out_data, 64'h3000_3001_3002_3003);
    end
  endtask

  task automatic test_simul_push_pop();
    logic [63:0] exp_row;
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 16'h4000 + 16'(i), 0, 0);
    for (int r = 1; r <= 5; r++) begin
      for (int i = 0; i < 3; i++) step(1, 16'h4000 + 16'(r*16 + i), 0, 0);
      step(1, 16'h4000 + 16'(r*16 + 3), 1, 0);
      exp_row = {16'h4000 + 16'(r*16), 16'h4000 + 16'(r*16+1),
                 16'h4000 + 16'(r*16+2), 16'h4000 + 16'(r*16+3)};
      vectors++;
      if (row_count !== 2'd1 || out_data !== exp_row) begin
        miscompares++;
        $display("FAIL simul_row%0d rc=%0d od=%h exp 1 %h", r, row_count, out_data, exp_row);
      end
    end
  endtask

  task automatic test_streaming();
    int rows_seen = 0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_ready%0d got %b exp 1", i, in_ready);
      end
      if (out_valid) begin
        rows_seen++;
        vectors++;
        if (out_data !== m_data()) begin
          miscompares++;
          $display("FAIL stream_row got %h exp %h", out_data, m_data());
        end
      end
      step(i < 16, 16'h5000 + 16'(i), 1, 0);
    end
    vectors++;
    if (rows_seen != 4 || ovf !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_rows got %0d ovf=%b ov=%b exp 4 0 0", rows_seen, ovf, out_valid);
    end
  endtask

`ifdef SYSARR_OUTBUF_FLUSH_EN
  task automatic test_flush();
    do_reset();
    step(1, 16'hAAAA, 0, 0);
    step(1, 16'hBBBB, 0, 0);
    step(0, 0, 0, 1);
    vectors++;
    if (out_data !== 64'hAAAA_BBBB_0000_0000 || fill !== 2'd0 || row_count !== 2'd1) begin
      miscompares++;
      $display("FAIL flush_row od=%h fill=%0d rc=%0d exp %h 0 1", out_data, fill, row_count, 64'hAAAA_BBBB_0000_0000);
    end
    step(0, 0, 0, 1);
    vectors++;
    if (row_count !== 2'd1) begin
      miscompares++;
      $display("FAIL flush_empty rc=%0d exp 1", row_count);
    end
  endtask
`endif

  task automatic test_random();
    bit sh, ordy, fl;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      sh = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) == 0);
      fl = 0;
`ifdef SYSARR_OUTBUF_FLUSH_EN
      fl = ($urandom_range(0, 7) == 0);
`endif
      step(sh, 16'($urandom), ordy, fl);
      vectors++;
      if (out_data !== m_data() || out_valid !== (q.size() != 0)) begin
        miscompares++;
        $display("FAIL rand_data c=%0d od=%h exp %h", c, out_data, m_data());
      end
      vectors++;
      if (row_count !== 2'(q.size()) || fill !== 2'(part.size())
          || ovf !== m_ovf || in_ready !== m_ir()) begin
        miscompares++;
        $display("FAIL rand_state c=%0d rc=%0d fill=%0d ovf=%b ir=%b exp %0d %0d %b %b",
                 c, row_count, fill, ovf, in_ready, q.size(), part.size(), m_ovf, m_ir());
      end
    end
  endtask

  initial begin
    m_ovf = 0;
    test_reset();
    test_single_row();
    test_backpressure();
    test_simul_push_pop();
    test_streaming();
`ifdef SYSARR_OUTBUF_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
